// File: rtl/sysx_slave_endpoint_if.sv
// sysX slave endpoint signal bundle: serial bus pins plus local rx/tx word ports.
// Latency: none, wires only.
// Backpressure: tx side is valid/ready; rx side has none (strobe only).
interface sysx_slave_endpoint_if;
    logic        iBusClock;
    logic [1:0]  iBusSelect;
    logic [7:0]  iBusMOSI;
    logic [7:0]  oBusMISO;
    logic        oBusMISOEn;
    logic        oBusInterrupt;
    logic [31:0] oRxData;
    logic        oRxValid;
    logic        oFrameError;
    logic [31:0] iTxData;
    logic        iTxValid;
    logic        oTxReady;

    // endpoint side
    modport slave (
        input  iBusClock, iBusSelect, iBusMOSI, iTxData, iTxValid,
        output oBusMISO, oBusMISOEn, oBusInterrupt, oRxData, oRxValid,
               oFrameError, oTxReady
    );

    // bus master / local host side
    modport master (
        output iBusClock, iBusSelect, iBusMOSI, iTxData, iTxValid,
        input  oBusMISO, oBusMISOEn, oBusInterrupt, oRxData, oRxValid,
               oFrameError, oTxReady
    );
endinterface

// File: rtl/sysx_slave_endpoint.sv
// sysX v1 slave endpoint: oversampled bus clock, 4-byte MOSI deserialiser, MISO serialiser.
// Latency: pin edge -> event 2 iClk; oRxValid/oRxData 3 iClk after Store pin rise; MISO 3 iClk after pin fall.
// Backpressure: tx holding register is valid/ready (ready = empty); rx has none, new commit overwrites.
module sysx_slave_endpoint #(
    parameter logic [1:0] pSelectId = 2'h1
) (
    input  logic                  iClk,
    input  logic                  iReset,
    sysx_slave_endpoint_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ARMED, ST_DATA, ST_COMMIT, ST_DONE, ST_LOCKOUT
    } state_t;

    // synchronisers (never reset so edge history survives a local reset)
    logic        clk_s1_q, clk_s2_q, clk_s3_q;
    logic        clk_s1_d, clk_s2_d, clk_s3_d;
    logic [1:0]  sel_s1_q, sel_s2_q, sel_s1_d, sel_s2_d;
    logic [7:0]  mosi_s1_q, mosi_s2_q, mosi_s1_d, mosi_s2_d;

    // frame and holding state
    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] rx_shift_q, rx_shift_d;
    logic [31:0] tx_shift_q, tx_shift_d;
    logic        used_hold_q, used_hold_d;
    logic [31:0] hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [31:0] rx_data_q, rx_data_d;
    logic        rx_vld_q, rx_vld_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  miso_q, miso_d;
    logic        miso_en_q, miso_en_d;

    logic bus_rise, bus_fall, selected, tx_accept;

    assign bus_rise  = clk_s2_q & ~clk_s3_q;
    assign bus_fall  = ~clk_s2_q & clk_s3_q;
    assign selected  = (sel_s2_q == pSelectId);
    assign tx_accept = bus.iTxValid & ~hold_full_q;

    // next-state: synchronisers, frame FSM, MISO serialiser, tx holding register
    always_comb begin
        clk_s1_d    = bus.iBusClock;
        clk_s2_d    = clk_s1_q;
        clk_s3_d    = clk_s2_q;
        sel_s1_d    = bus.iBusSelect;
        sel_s2_d    = sel_s1_q;
        mosi_s1_d   = bus.iBusMOSI;
        mosi_s2_d   = mosi_s1_q;
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        used_hold_d = used_hold_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_vld_d    = 1'b0;
        frame_err_d = 1'b0;
        miso_d      = miso_q;
        miso_en_d   = selected;

        case (state_q)
            ST_IDLE: begin
                if (selected) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!selected) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (bus_rise) begin
                    // Load: holding state is sampled before any same-cycle accept
                    tx_shift_d  = hold_full_q ? hold_q : 32'h0BADC0DE;
                    used_hold_d = hold_full_q;
                    byte_cnt_d  = 2'd0;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!selected) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (bus_rise) begin
                    rx_shift_d[{byte_cnt_q, 3'b000} +: 8] = mosi_s2_q;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (!selected) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (bus_rise) begin
                    rx_data_d = rx_shift_q;
                    rx_vld_d  = 1'b1;
                    if (used_hold_q) hold_full_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE, ST_LOCKOUT: begin
                if (!selected) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // MISO: next byte LowLow-first on each fall of an active frame
        if (!selected) begin
            miso_d = 8'h00;
        end else if (bus_fall && (state_q == ST_DATA || state_q == ST_COMMIT)) begin
            miso_d     = tx_shift_q[7:0];
            tx_shift_d = {8'h00, tx_shift_q[31:8]};
        end

        // holding register accept; cannot collide with consume (needs full)
        if (tx_accept) begin
            hold_d      = bus.iTxData;
            hold_full_d = 1'b1;
        end
    end

    // state registers; reset while selected parks in LOCKOUT
    always_ff @(posedge iClk) begin
        clk_s1_q  <= clk_s1_d;
        clk_s2_q  <= clk_s2_d;
        clk_s3_q  <= clk_s3_d;
        sel_s1_q  <= sel_s1_d;
        sel_s2_q  <= sel_s2_d;
        mosi_s1_q <= mosi_s1_d;
        mosi_s2_q <= mosi_s2_d;
        if (iReset) begin
            state_q     <= selected ? ST_LOCKOUT : ST_IDLE;
            byte_cnt_q  <= 2'd0;
            rx_shift_q  <= 32'h0;
            tx_shift_q  <= 32'h0;
            used_hold_q <= 1'b0;
            hold_q      <= 32'h0;
            hold_full_q <= 1'b0;
            rx_data_q   <= 32'h0;
            rx_vld_q    <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 8'h00;
            miso_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            used_hold_q <= used_hold_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_vld_q    <= rx_vld_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
            miso_en_q   <= miso_en_d;
        end
    end

    assign bus.oBusMISO      = miso_q;
    assign bus.oBusMISOEn    = miso_en_q;
    assign bus.oBusInterrupt = hold_full_q;
    assign bus.oTxReady      = ~hold_full_q;
    assign bus.oRxData       = rx_data_q;
    assign bus.oRxValid      = rx_vld_q;
    assign bus.oFrameError   = frame_err_q;

endmodule

// File: tb/tb_sysx_slave_endpoint.sv
// Bench for sysx_slave_endpoint: directed frames, expected responses queued at issue time.
// Monitors pop and compare on oRxValid / oFrameError strobes and on master MISO samples.
module tb_sysx_slave_endpoint;

    logic iClk;
    logic iReset;
    sysx_slave_endpoint_if bif();

    sysx_slave_endpoint #(.pSelectId(2'h1)) dut (
        .iClk   (iClk),
        .iReset (iReset),
        .bus    (bif.slave)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic [31:0] data;
        logic        irq;
    } rx_exp_t;

    rx_exp_t     exp_rx[$];
    int          exp_err[$];
    logic [7:0]  exp_miso[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          cap_miso = 1'b0;

    task automatic cyc(input int n);
        repeat (n) @(negedge iClk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void push_rx(input logic [31:0] d, input logic irq);
        rx_exp_t e;
        e.data = d;
        e.irq  = irq;
        exp_rx.push_back(e);
    endfunction

    // receive strobe and frame-error monitor
    always @(negedge iClk) begin
        if (bif.oRxValid) begin
            n_checks++;
            if (exp_rx.size() == 0) begin
                $display("FAIL rx_unexpected: got data %h, no strobe expected", bif.oRxData);
            end else begin
                rx_exp_t e;
                e = exp_rx.pop_front();
                if (bif.oRxData === e.data && bif.oBusInterrupt === e.irq) n_pass++;
                else $display("FAIL rx_commit: got data %h irq %b expected data %h irq %b",
                              bif.oRxData, bif.oBusInterrupt, e.data, e.irq);
            end
        end
        if (bif.oFrameError) begin
            n_checks++;
            if (exp_err.size() == 0) begin
                $display("FAIL frame_err_unexpected: got strobe 1 expected 0");
            end else begin
                void'(exp_err.pop_front());
                n_pass++;
            end
        end
    end

    // master samples MISO on bus clock rise
    always @(posedge bif.iBusClock) begin
        if (cap_miso) begin
            n_checks++;
            if (exp_miso.size() == 0) begin
                $display("FAIL miso_unexpected: got %h, no sample expected", bif.oBusMISO);
            end else begin
                logic [7:0] e;
                e = exp_miso.pop_front();
                if (bif.oBusMISO === e && bif.oBusMISOEn === 1'b1) n_pass++;
                else $display("FAIL miso_byte: got %h en %b expected %h en 1",
                              bif.oBusMISO, bif.oBusMISOEn, e);
            end
        end
    end

    // one bus clock period, 8 iClk; optional tx offer landing on the rise event cycle
    task automatic bus_pulse(input logic [7:0] mosi, input bit cap, input bit offer);
        bif.iBusMOSI = mosi;
        cap_miso     = cap;
        cyc(4);
        bif.iBusClock = 1'b1;
        if (offer) begin
            cyc(2);
            bif.iTxValid = 1'b1;
            cyc(1);
            bif.iTxValid = 1'b0;
            cyc(1);
        end else begin
            cyc(4);
        end
        bif.iBusClock = 1'b0;
        cap_miso      = 1'b0;
    endtask

    task automatic run_frame(input logic [1:0] sel, input logic [31:0] mosi_word, input int n_rises,
                             input bit chk_miso, input logic [31:0] miso_word, input bit offer_at_load);
        logic [7:0] b;
        bit         cap;
        bif.iBusSelect = sel;
        cyc(6);
        for (int r = 0; r < n_rises; r++) begin
            b   = (r >= 1 && r <= 4) ? mosi_word[8*(r-1) +: 8] : 8'h00;
            cap = chk_miso && (r >= 1) && (r <= 4);
            if (cap) exp_miso.push_back(miso_word[8*(r-1) +: 8]);
            bus_pulse(b, cap, offer_at_load && (r == 0));
        end
        cyc(4);
        bif.iBusSelect = 2'h0;
        cyc(6);
    endtask

    task automatic tx_offer(input logic [31:0] w);
        bif.iTxData  = w;
        bif.iTxValid = 1'b1;
        cyc(1);
        bif.iTxValid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        iReset         = 1'b1;
        bif.iBusClock  = 1'b0;
        bif.iBusSelect = 2'h0;
        bif.iBusMOSI   = 8'h00;
        bif.iTxData    = 32'h0;
        bif.iTxValid   = 1'b0;
        cyc(5);
        check("rst_miso",     {24'h0, bif.oBusMISO},      32'h0);
        check("rst_miso_en",  {31'h0, bif.oBusMISOEn},    32'h0);
        check("rst_irq",      {31'h0, bif.oBusInterrupt}, 32'h0);
        check("rst_rx_data",  bif.oRxData,                32'h0);
        check("rst_rx_vld",   {31'h0, bif.oRxValid},      32'h0);
        check("rst_ferr",     {31'h0, bif.oFrameError},   32'h0);
        check("rst_tx_ready", {31'h0, bif.oTxReady},      32'h1);
        iReset = 1'b0;
        cyc(2);

        // empty holding: default word returned
        push_rx(32'h12345678, 1'b0);
        run_frame(2'h1, 32'h12345678, 6, 1'b1, 32'h0BADC0DE, 1'b0);

        // loaded holding: interrupt before, consumed at commit
        tx_offer(32'hCAFEF00D);
        check("load_tx_ready", {31'h0, bif.oTxReady},      32'h0);
        check("load_irq",      {31'h0, bif.oBusInterrupt}, 32'h1);
        push_rx(32'h89ABCDEF, 1'b0);
        run_frame(2'h1, 32'h89ABCDEF, 6, 1'b1, 32'hCAFEF00D, 1'b0);
        check("post_tx_ready", {31'h0, bif.oTxReady},      32'h1);
        check("post_irq",      {31'h0, bif.oBusInterrupt}, 32'h0);

        // abort after third rise: error strobe, holding kept for next frame
        tx_offer(32'hCAFEF00D);
        exp_err.push_back(1);
        run_frame(2'h1, 32'h11223344, 3, 1'b1, 32'hCAFEF00D, 1'b0);
        check("abort_irq_kept", {31'h0, bif.oBusInterrupt}, 32'h1);
        push_rx(32'h01020304, 1'b0);
        run_frame(2'h1, 32'h01020304, 6, 1'b1, 32'hCAFEF00D, 1'b0);

        // accept on the Load edge: default word now, new word pending afterwards
        bif.iTxData = 32'h600DF00D;
        push_rx(32'h55667788, 1'b1);
        run_frame(2'h1, 32'h55667788, 6, 1'b1, 32'h0BADC0DE, 1'b1);
        check("sim_irq_pending", {31'h0, bif.oBusInterrupt}, 32'h1);
        push_rx(32'h99AABBCC, 1'b0);
        run_frame(2'h1, 32'h99AABBCC, 6, 1'b1, 32'h600DF00D, 1'b0);

        // reset mid-frame with select held: lockout until deselect
        bif.iBusSelect = 2'h1;
        cyc(6);
        for (int r = 0; r < 3; r++) bus_pulse(8'hEE, 1'b0, 1'b0);
        iReset = 1'b1;
        cyc(3);
        iReset = 1'b0;
        cyc(1);
        check("lock_rx_data",  bif.oRxData,               32'h0);
        check("lock_tx_ready", {31'h0, bif.oTxReady},     32'h1);
        for (int r = 0; r < 6; r++) bus_pulse(8'h5A, 1'b0, 1'b0);
        cyc(4);
        bif.iBusSelect = 2'h0;
        cyc(6);
        push_rx(32'hDEADBEEF, 1'b0);
        run_frame(2'h1, 32'hDEADBEEF, 6, 1'b1, 32'h0BADC0DE, 1'b0);

        // other chip-select: endpoint stays off the bus
        bif.iBusSelect = 2'h2;
        cyc(6);
        check("other_miso_en", {31'h0, bif.oBusMISOEn}, 32'h0);
        check("other_miso",    {24'h0, bif.oBusMISO},   32'h0);
        run_frame(2'h2, 32'h0F0F0F0F, 6, 1'b0, 32'h0, 1'b0);

        cyc(20);
        check("drain_rx",   exp_rx.size(),   32'h0);
        check("drain_err",  exp_err.size(),  32'h0);
        check("drain_miso", exp_miso.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
